// File: rtl/vpu_instr_sequencer.sv
// ----------------------------------------------------------------------------
// vpu_instr_sequencer
//
// Instruction-driven controller for the systolic array. Fetches 32-bit
// instructions from the instruction memory, decodes the one-hot opcode field
// (highest set bit wins) and drives the array's load/swap/shift/accumulate/
// clear controls. Also runs the DPRAM bursts that fill the operand buffers
// and write accumulator bytes back.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   start / busy / done       run control: start at pc=0, busy until HALT,
//                             done pulses on entering HALT
//   rd_addr / rd_data         instruction memory read port (1-cycle latency)
//   addr_b/we_b/din_b/dout_b  DPRAM port B (1-cycle read latency)
//   load_en_*/addr_*/data_in_* operand buffer write strobes, index, data
//   swap_buffers_*            buffer swap pulses
//   shift_en_right/down       shift pulses; acc_en accumulate enable
//   acc_rst, buffer_rst_*     clear pulses
//   addr_acc / acc_out        accumulator select (registered) and its value
// ----------------------------------------------------------------------------
module vpu_instr_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int MATRIX_SIZE    = 8,
  parameter int ACC_WIDTH      = 32,
  parameter int INSTR_DEPTH    = 256,
  parameter int DP_ADDR_WIDTH  = 10,
  parameter int ADDR_WIDTH     = $clog2(MATRIX_SIZE),
  parameter int ACC_ADDR_WIDTH = $clog2(MATRIX_SIZE*MATRIX_SIZE),
  parameter int PC_W           = $clog2(INSTR_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [PC_W-1:0]           rd_addr,
  input  logic [31:0]               rd_data,
  output logic [DP_ADDR_WIDTH-1:0]  addr_b,
  output logic                      we_b,
  output logic [DATA_WIDTH-1:0]     din_b,
  input  logic [DATA_WIDTH-1:0]     dout_b,
  output logic                      load_en_left,
  output logic                      load_en_top,
  output logic [ADDR_WIDTH-1:0]     addr_left,
  output logic [ADDR_WIDTH-1:0]     addr_top,
  output logic [DATA_WIDTH-1:0]     data_in_left,
  output logic [DATA_WIDTH-1:0]     data_in_top,
  output logic                      swap_buffers_left,
  output logic                      swap_buffers_top,
  output logic                      shift_en_right,
  output logic                      shift_en_down,
  output logic                      acc_en,
  output logic                      acc_rst,
  output logic                      buffer_rst_left,
  output logic                      buffer_rst_top,
  output logic [ACC_ADDR_WIDTH-1:0] addr_acc,
  input  logic [ACC_WIDTH-1:0]      acc_out
);

  // Burst counter must reach MATRIX_SIZE (load) and 3 (accumulator write).
  localparam int CNT_W = ($clog2(MATRIX_SIZE+1) > 2) ? $clog2(MATRIX_SIZE+1) : 2;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_BURST, S_WAIT, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_HALT, OP_LOAD_LEFT, OP_LOAD_TOP, OP_SWAP_LEFT, OP_SWAP_TOP,
    OP_SHIFT_RIGHT, OP_SHIFT_DOWN, OP_LOAD_ACC, OP_WRITE_ACC, OP_WAIT,
    OP_JUMP, OP_CLR, OP_NOP
  } op_e;

  state_e           state;
  op_e              op_q;
  op_e              dec_op;
  logic [PC_W-1:0]  pc;
  logic [CNT_W-1:0] cnt;
  logic [12:0]      wait_cnt;
  logic             unused_bits;

  // Highest set opcode bit wins; all-zero opcode field is HALT.
  function automatic op_e decode_op(input logic [11:0] f);
    op_e op;
    op = OP_HALT;
    if      (f[11]) op = OP_LOAD_LEFT;
    else if (f[10]) op = OP_LOAD_TOP;
    else if (f[9])  op = OP_SWAP_LEFT;
    else if (f[8])  op = OP_SWAP_TOP;
    else if (f[7])  op = OP_SHIFT_RIGHT;
    else if (f[6])  op = OP_SHIFT_DOWN;
    else if (f[5])  op = OP_LOAD_ACC;
    else if (f[4])  op = OP_WRITE_ACC;
    else if (f[3])  op = OP_WAIT;
    else if (f[2])  op = OP_JUMP;
    else if (f[1])  op = OP_CLR;
    else if (f[0])  op = OP_NOP;
    return op;
  endfunction

  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] p);
    if (p == PC_W'(INSTR_DEPTH-1)) return '0;
    return p + PC_W'(1);
  endfunction

  // Little-endian byte i of the selected accumulator.
  function automatic logic [DATA_WIDTH-1:0] acc_byte(input logic [ACC_WIDTH-1:0] a,
                                                     input logic [1:0] i);
    return a[DATA_WIDTH*i +: DATA_WIDTH];
  endfunction

  assign dec_op      = decode_op(rd_data[31:20]);
  assign rd_addr     = pc;
  assign unused_bits = ^rd_data[19:16];

  // dout_b arrives one cycle after addr_b, aligned with the registered strobe.
  assign data_in_left = {DATA_WIDTH{load_en_left}} & dout_b;
  assign data_in_top  = {DATA_WIDTH{load_en_top}}  & dout_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= S_IDLE;
      op_q              <= OP_HALT;
      pc                <= '0;
      cnt               <= '0;
      wait_cnt          <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      addr_b            <= '0;
      we_b              <= 1'b0;
      din_b             <= '0;
      load_en_left      <= 1'b0;
      load_en_top       <= 1'b0;
      addr_left         <= '0;
      addr_top          <= '0;
      swap_buffers_left <= 1'b0;
      swap_buffers_top  <= 1'b0;
      shift_en_right    <= 1'b0;
      shift_en_down     <= 1'b0;
      acc_en            <= 1'b0;
      acc_rst           <= 1'b0;
      buffer_rst_left   <= 1'b0;
      buffer_rst_top    <= 1'b0;
      addr_acc          <= '0;
    end else begin
      done              <= 1'b0;
      we_b              <= 1'b0;
      load_en_left      <= 1'b0;
      load_en_top       <= 1'b0;
      swap_buffers_left <= 1'b0;
      swap_buffers_top  <= 1'b0;
      shift_en_right    <= 1'b0;
      shift_en_down     <= 1'b0;
      acc_en            <= 1'b0;
      acc_rst           <= 1'b0;
      buffer_rst_left   <= 1'b0;
      buffer_rst_top    <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (start) begin
            pc    <= '0;
            busy  <= 1'b1;
            state <= S_FETCH;
          end
        end

        // rd_addr = pc this cycle; instruction is valid next cycle.
        S_FETCH: state <= S_DECODE;

        S_DECODE: begin
          op_q <= dec_op;
          cnt  <= '0;
          pc   <= (dec_op == OP_JUMP) ? rd_data[PC_W-1:0] : pc_inc(pc);
          unique case (dec_op)
            OP_HALT: begin
              done  <= 1'b1;
              state <= S_HALT;
            end
            OP_LOAD_LEFT, OP_LOAD_TOP: begin
              addr_b <= rd_data[DP_ADDR_WIDTH-1:0];
              state  <= S_BURST;
            end
            OP_WRITE_ACC: begin
              we_b   <= 1'b1;
              addr_b <= rd_data[DP_ADDR_WIDTH-1:0];
              din_b  <= acc_byte(acc_out, 2'd0);
              state  <= S_BURST;
            end
            OP_WAIT: begin
              wait_cnt <= rd_data[12:0];
              state    <= (rd_data[12:0] == '0) ? S_FETCH : S_WAIT;
            end
            default: begin
              state <= S_EXEC;
              unique case (dec_op)
                OP_SWAP_LEFT:  swap_buffers_left <= 1'b1;
                OP_SWAP_TOP:   swap_buffers_top  <= 1'b1;
                OP_SHIFT_RIGHT: begin
                  shift_en_right <= 1'b1;
                  acc_en         <= rd_data[13];
                end
                OP_SHIFT_DOWN: begin
                  shift_en_down <= 1'b1;
                  acc_en        <= rd_data[13];
                end
                OP_LOAD_ACC:   addr_acc <= rd_data[ACC_ADDR_WIDTH-1:0];
                OP_CLR: begin
                  acc_rst         <= 1'b1;
                  buffer_rst_left <= rd_data[14];
                  buffer_rst_top  <= rd_data[15];
                end
                default: ;
              endcase
            end
          endcase
        end

        S_EXEC: state <= S_FETCH;

        S_BURST: begin
          if (op_q == OP_WRITE_ACC) begin
            if (cnt == CNT_W'(3)) begin
              state <= S_FETCH;
            end else begin
              we_b   <= 1'b1;
              addr_b <= addr_b + DP_ADDR_WIDTH'(1);
              din_b  <= acc_byte(acc_out, cnt[1:0] + 2'd1);
              cnt    <= cnt + CNT_W'(1);
            end
          end else begin
            // Beat cnt presents the address; the buffer write for it lands
            // one cycle later, so the burst runs MATRIX_SIZE+1 cycles.
            if (cnt == CNT_W'(MATRIX_SIZE)) begin
              state <= S_FETCH;
            end else begin
              if (op_q == OP_LOAD_LEFT) begin
                load_en_left <= 1'b1;
                addr_left    <= cnt[ADDR_WIDTH-1:0];
              end else begin
                load_en_top <= 1'b1;
                addr_top    <= cnt[ADDR_WIDTH-1:0];
              end
              addr_b <= addr_b + DP_ADDR_WIDTH'(1);
              cnt    <= cnt + CNT_W'(1);
            end
          end
        end

        S_WAIT: begin
          if (wait_cnt == 13'd1) state <= S_FETCH;
          else                   wait_cnt <= wait_cnt - 13'd1;
        end

        S_HALT: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vpu_instr_sequencer.sv
module tb_vpu_instr_sequencer;

  localparam int DW = 8, M = 8, AW = 32, DEPTH = 256, DPW = 10;
  localparam int ADW = 3, AAW = 6, PCW = 8;

  logic clk = 1'b0;
  logic rst, start;
  logic busy, done, we_b;
  logic [PCW-1:0] rd_addr;
  logic [31:0] rd_data = '0;
  logic [DPW-1:0] addr_b;
  logic [DW-1:0] din_b, dout_b = '0;
  logic load_en_left, load_en_top;
  logic [ADW-1:0] addr_left, addr_top;
  logic [DW-1:0] data_in_left, data_in_top;
  logic swap_buffers_left, swap_buffers_top, shift_en_right, shift_en_down;
  logic acc_en, acc_rst, buffer_rst_left, buffer_rst_top;
  logic [AAW-1:0] addr_acc;
  logic [AW-1:0] acc_out;

  always #5 clk = ~clk;

  vpu_instr_sequencer #(
    .DATA_WIDTH(DW), .MATRIX_SIZE(M), .ACC_WIDTH(AW), .INSTR_DEPTH(DEPTH),
    .DP_ADDR_WIDTH(DPW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .addr_b(addr_b), .we_b(we_b), .din_b(din_b), .dout_b(dout_b),
    .load_en_left(load_en_left), .load_en_top(load_en_top),
    .addr_left(addr_left), .addr_top(addr_top),
    .data_in_left(data_in_left), .data_in_top(data_in_top),
    .swap_buffers_left(swap_buffers_left), .swap_buffers_top(swap_buffers_top),
    .shift_en_right(shift_en_right), .shift_en_down(shift_en_down),
    .acc_en(acc_en), .acc_rst(acc_rst),
    .buffer_rst_left(buffer_rst_left), .buffer_rst_top(buffer_rst_top),
    .addr_acc(addr_acc), .acc_out(acc_out)
  );

  // Memories around the sequencer
  logic [31:0]   imem    [DEPTH];
  logic [DW-1:0] dmem    [1024];
  logic [DW-1:0] m_mem   [1024];
  logic [AW-1:0] acc_tab [64];
  logic          init_req = 1'b0;

  assign acc_out = acc_tab[addr_acc];

  always @(posedge clk) rd_data <= imem[rd_addr];

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 1024; i++) dmem[i] <= m_mem[i];
    end else if (we_b) begin
      dmem[addr_b] <= din_b;
    end
    dout_b <= dmem[addr_b];
  end

  // Per-cycle observation, address/data fields masked when their strobe is low
  typedef struct packed {
    logic           busy, done;
    logic [7:0]     rd_addr;
    logic           ldl, ldt;
    logic [2:0]     al, at;
    logic [7:0]     dl, dt;
    logic           swl, swt, shr, shd, acc_en, acc_rst, brl, brt, we;
    logic [5:0]     addr_acc;
  } obs_t;

  obs_t exp_q[$];
  int   ab_q[$];
  int   din_q[$];

  int         n_err = 0, n_checks = 0;
  logic [5:0] m_acc = '0;
  int         m_pc  = 0;

  function automatic obs_t sample_dut();
    obs_t o;
    o.busy = busy; o.done = done; o.rd_addr = rd_addr;
    o.ldl = load_en_left; o.ldt = load_en_top;
    o.al = load_en_left ? addr_left : 3'd0;
    o.at = load_en_top ? addr_top : 3'd0;
    o.dl = load_en_left ? data_in_left : 8'd0;
    o.dt = load_en_top ? data_in_top : 8'd0;
    o.swl = swap_buffers_left; o.swt = swap_buffers_top;
    o.shr = shift_en_right; o.shd = shift_en_down;
    o.acc_en = acc_en; o.acc_rst = acc_rst;
    o.brl = buffer_rst_left; o.brt = buffer_rst_top;
    o.we = we_b; o.addr_acc = addr_acc;
    return o;
  endfunction

  function automatic obs_t base_obs(input logic b, input int rd);
    obs_t o;
    o = '0;
    o.busy = b;
    o.rd_addr = rd[7:0];
    o.addr_acc = m_acc;
    return o;
  endfunction

  function automatic logic [31:0] mk(input int bit_i, input int flags, input int addr);
    logic [31:0] w;
    w = '0;
    if (bit_i >= 20) w[bit_i] = 1'b1;
    w[17:13] = flags[4:0];
    w[12:0]  = addr[12:0];
    return w;
  endfunction

  task automatic check(input string tag, input int idx, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 0,
          64'({busy, done, rd_addr, we_b, load_en_left, load_en_top,
               swap_buffers_left, swap_buffers_top, shift_en_right, shift_en_down,
               acc_en, acc_rst, buffer_rst_left, buffer_rst_top}), 64'd0);
    check({tag, "_dat"}, 0,
          64'({addr_b, din_b, addr_left, addr_top, data_in_left, data_in_top,
               addr_acc}), 64'd0);
  endtask

  task automatic push(input obs_t e, input int ab, input int dn);
    exp_q.push_back(e); ab_q.push_back(ab); din_q.push_back(dn);
  endtask

  // Instruction-level reference: walks the program and emits the expected
  // observation for every busy cycle, from the first FETCH to the HALT cycle.
  task automatic build_trace();
    int pc_l, npc, top, addr, flags, cyc;
    logic [31:0] ins;
    bit halted;
    obs_t e;
    exp_q.delete(); ab_q.delete(); din_q.delete();
    pc_l = 0; cyc = 0; halted = 0;
    while (!halted && cyc < 4000) begin
      ins = imem[pc_l];
      top = -1;
      for (int b = 31; b >= 20; b--) if (top < 0 && ins[b]) top = b;
      addr  = int'(ins[12:0]);
      flags = int'(ins[17:13]);
      npc   = (top == 22) ? (addr % DEPTH) : ((pc_l + 1) % DEPTH);
      push(base_obs(1'b1, pc_l), -1, -1);
      push(base_obs(1'b1, pc_l), -1, -1);
      cyc += 2;
      case (top)
        -1: begin
          e = base_obs(1'b1, npc); e.done = 1'b1;
          push(e, -1, -1);
          halted = 1;
        end
        31, 30: begin
          for (int k = 0; k <= M; k++) begin
            e = base_obs(1'b1, npc);
            if (k >= 1) begin
              if (top == 31) begin
                e.ldl = 1'b1; e.al = 3'(k - 1); e.dl = m_mem[(addr + k - 1) % 1024];
              end else begin
                e.ldt = 1'b1; e.at = 3'(k - 1); e.dt = m_mem[(addr + k - 1) % 1024];
              end
            end
            push(e, (k < M) ? (addr + k) % 1024 : -1, -1);
          end
          cyc += M + 1;
        end
        24: begin
          for (int i = 0; i < 4; i++) begin
            e = base_obs(1'b1, npc); e.we = 1'b1;
            push(e, (addr + i) % 1024, int'(acc_tab[m_acc][8*i +: 8]));
            m_mem[(addr + i) % 1024] = acc_tab[m_acc][8*i +: 8];
          end
          cyc += 4;
        end
        23: begin
          for (int i = 0; i < addr; i++) push(base_obs(1'b1, npc), -1, -1);
          cyc += addr;
        end
        default: begin
          if (top == 25) m_acc = 6'(addr);
          e = base_obs(1'b1, npc);
          case (top)
            29: e.swl = 1'b1;
            28: e.swt = 1'b1;
            27: begin e.shr = 1'b1; e.acc_en = flags[0]; end
            26: begin e.shd = 1'b1; e.acc_en = flags[0]; end
            21: begin e.acc_rst = 1'b1; e.brl = flags[1]; e.brt = flags[2]; end
            default: ;
          endcase
          push(e, -1, -1);
          cyc += 1;
        end
      endcase
      pc_l = npc;
    end
    m_pc = pc_l;
  endtask

  // Runs the program in imem from start; stop_at >= 0 ends after that cycle.
  // poke_busy asserts start once mid-run, which must be ignored.
  task automatic run_program(input string tag, input int stop_at, input bit poke_busy);
    int len, poke;
    obs_t got;
    @(negedge clk) init_req = 1'b1;
    @(negedge clk) init_req = 1'b0;
    build_trace();
    len  = exp_q.size();
    poke = poke_busy ? $urandom_range(0, len - 2) : -1;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      got = sample_dut();
      check({tag, "_cyc"}, i, 64'(got), 64'(exp_q[i]));
      if (ab_q[i] >= 0)  check({tag, "_addr_b"}, i, 64'(addr_b), 64'(ab_q[i]));
      if (din_q[i] >= 0) check({tag, "_din_b"}, i, 64'(din_b), 64'(din_q[i]));
      start = (i == poke);
      if (i == stop_at) break;
    end
    start = 1'b0;
    if (stop_at < 0) begin
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        check({tag, "_idle"}, i, 64'(sample_dut()), 64'(base_obs(1'b0, m_pc)));
      end
    end
  endtask

  task automatic clr_imem();
    for (int i = 0; i < DEPTH; i++) imem[i] = '0;
  endtask

  task automatic rand_program();
    int L, b, a;
    logic [31:0] w;
    clr_imem();
    L = $urandom_range(4, 12);
    for (int j = 0; j < L - 1; j++) begin
      b = 31 - $urandom_range(0, 11);
      w = '0;
      w[b] = 1'b1;
      if ($urandom_range(0, 3) == 0)
        for (int bb = 20; bb < b; bb++) if ($urandom_range(0, 1) == 1) w[bb] = 1'b1;
      w[19:13] = 7'($urandom);
      case (b)
        22:      a = $urandom_range(j + 1, L - 1);
        23:      a = $urandom_range(0, 6);
        default: a = $urandom_range(0, 8191);
      endcase
      w[12:0] = 13'(a);
      imem[j] = w;
    end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    clr_imem();
    for (int i = 0; i < 1024; i++) m_mem[i] = 8'($urandom);
    for (int i = 0; i < 64; i++) acc_tab[i] = $urandom;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    // NOP then HALT
    clr_imem();
    imem[0] = mk(20, 0, 0);
    run_program("nop_halt", -1, 0);

    // LOAD_LEFT from 0x010 with 1..8
    for (int k = 0; k < 8; k++) m_mem[16 + k] = 8'(k + 1);
    clr_imem();
    imem[0] = mk(31, 0, 'h010);
    run_program("load_left", -1, 0);

    // LOAD_ACC 5, WRITE_ACC_OUT across the DPRAM wrap, read it back via LOAD_TOP
    acc_tab[5] = 32'hAABBCCDD;
    clr_imem();
    imem[0] = mk(25, 0, 5);
    imem[1] = mk(24, 0, 'h3FE);
    imem[2] = mk(30, 0, 'h3FC);
    run_program("acc_write", -1, 0);

    // WAIT 10 then SHIFT_RIGHT with accumulate
    clr_imem();
    imem[0] = mk(23, 0, 10);
    imem[1] = mk(27, 1, 0);
    run_program("wait_shift", -1, 0);

    // JUMP over a CLR
    clr_imem();
    imem[0] = mk(22, 0, 3);
    imem[1] = mk(21, 7, 0);
    imem[2] = mk(20, 0, 0);
    run_program("jump", -1, 0);

    // Several opcode bits: only LOAD_LEFT runs
    clr_imem();
    imem[0] = mk(31, 0, 'h020) | (32'h1 << 28);
    run_program("priority", -1, 0);

    // Swaps, shift down without accumulate, CLR with both buffer clears
    clr_imem();
    imem[0] = mk(29, 0, 0);
    imem[1] = mk(28, 0, 0);
    imem[2] = mk(26, 0, 0);
    imem[3] = mk(21, 6, 0);
    imem[4] = mk(21, 2, 0);
    run_program("pulses", -1, 0);

    // Reset while LOAD_TOP presents buffer index 4
    clr_imem();
    imem[0] = mk(30, 0, 'h155);
    run_program("rst_burst", 7, 0);
    #2 rst = 1'b0;
    #1 check_all_zero("rst_mid");
    m_pc = 0;
    m_acc = '0;
    @(negedge clk) rst = 1'b1;
    run_program("rst_rerun", -1, 0);

    // Random programs with a spurious start while busy
    for (int r = 0; r < 20; r++) begin
      rand_program();
      run_program($sformatf("rand%0d", r), -1, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
